// File: rtl/clk_synth_pkg.sv
// Shared constants and a helper for the clock-enable synthesiser.
// inc_for() turns a reference/output frequency pair into a rounded phase increment.
package clk_synth_pkg;

   localparam int          ACC_W_DEFAULT = 32;
   localparam logic [31:0] INC_DEFAULT   = 32'h8000_0000;

   // Rounded to nearest: (f_out * 2^acc_w + f_ref/2) / f_ref
   function automatic logic [63:0] inc_for(input longint unsigned f_ref_hz,
                                           input longint unsigned f_out_hz,
                                           input int unsigned     acc_w);
      logic [127:0] num;
      logic [127:0] den;
      num = ({64'd0, f_out_hz} << acc_w) + {64'd0, (f_ref_hz >> 1)};
      den = {64'd0, f_ref_hz};
      return 64'(num / den);
   endfunction

endpackage

// File: rtl/clk_synth_channel.sv
// One NCO channel: phase accumulator, increment, settle counter and
// registered ce/sq/locked outputs, with a load port for retune + phase preset.
module clk_synth_channel
   import clk_synth_pkg::*;
#(
   parameter int               ACC_W       = ACC_W_DEFAULT,
   parameter int               LOCK_CYCLES = 256,
   parameter logic [ACC_W-1:0] INC_RESET   = INC_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [ACC_W-1:0] load_inc_i,
   input  logic [ACC_W-1:0] load_phase_i,
   output logic             ce_o,
   output logic             sq_o,
   output logic             locked_o
);

   localparam int               CNT_W      = $clog2(LOCK_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LOCK_CYCLES);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] inc_q, inc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ce_q, ce_d;
   logic             locked_q, locked_d;
   logic [ACC_W:0]   sum;

   assign sum = {1'b0, acc_q} + {1'b0, inc_q};

   always_comb begin
      acc_d    = acc_q;
      inc_d    = inc_q;
      cnt_d    = cnt_q;
      ce_d     = 1'b0;
      locked_d = 1'b0;
      // A load wins over everything and never produces a ce from the preset itself
      if (load_i) begin
         inc_d = load_inc_i;
         acc_d = load_phase_i;
         cnt_d = CNT_RELOAD;
      end else if (!en_i) begin
         cnt_d = CNT_RELOAD;
      end else if (inc_q != '0) begin
         acc_d    = sum[ACC_W-1:0];
         ce_d     = sum[ACC_W];
         locked_d = locked_q | (cnt_q == '0);
         if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q    <= '0;
         inc_q    <= INC_RESET;
         cnt_q    <= CNT_RELOAD;
         ce_q     <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         inc_q    <= inc_d;
         cnt_q    <= cnt_d;
         ce_q     <= ce_d;
         locked_q <= locked_d;
      end
   end

   assign ce_o     = ce_q;
   assign sq_o     = acc_q[ACC_W-1];
   assign locked_o = locked_q;

endmodule

// File: rtl/clk_enable_synth.sv
// Multi-channel programmable clock-enable synthesiser (one NCO per channel).
// Holds the config handshake/decode, the cfg_err pulse and locked_all.
module clk_enable_synth
   import clk_synth_pkg::*;
#(
   parameter int               NUM_CH      = 4,
   parameter int               ACC_W       = ACC_W_DEFAULT,
   parameter int               LOCK_CYCLES = 256,
   parameter logic [ACC_W-1:0] INC_DEFAULT = clk_synth_pkg::INC_DEFAULT,
   localparam int              CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              refclk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] ch_enable,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]  cfg_inc,
   input  logic [ACC_W-1:0]  cfg_phase,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] ce_out,
   output logic [NUM_CH-1:0] sq_out,
   output logic [NUM_CH-1:0] locked,
   output logic              locked_all
);

   logic              rdy_q, rdy_d;
   logic              err_q, err_d;
   logic              accept;
   logic              ch_ok;
   logic [NUM_CH-1:0] load;

   assign accept = cfg_valid && rdy_q;
   assign ch_ok  = (int'(cfg_ch) < NUM_CH);

   // Ready drops for the one cycle in which the accepted write lands
   always_comb begin
      rdy_d = !accept;
      err_d = accept && !ch_ok;
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q <= 1'b1;
         err_q <= 1'b0;
      end else begin
         rdy_q <= rdy_d;
         err_q <= err_d;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign load[i] = accept && ch_ok && (int'(cfg_ch) == i);

      clk_synth_channel #(
         .ACC_W       (ACC_W),
         .LOCK_CYCLES (LOCK_CYCLES),
         .INC_RESET   (INC_DEFAULT)
      ) u_ch (
         .clk_i        (refclk),
         .rst_ni       (rst_n),
         .en_i         (ch_enable[i]),
         .load_i       (load[i]),
         .load_inc_i   (cfg_inc),
         .load_phase_i (cfg_phase),
         .ce_o         (ce_out[i]),
         .sq_o         (sq_out[i]),
         .locked_o     (locked[i])
      );
   end

   assign cfg_ready  = rdy_q;
   assign cfg_err    = err_q;
   assign locked_all = &locked;

endmodule

// File: tb/tb_clk_enable_synth.sv
// Directed bench for clk_enable_synth: per-cycle vector table plus hand-written
// reset / lock-all sequences. Increments and phases are in quarter turns (n * 2^30).
module tb_clk_enable_synth;
   import clk_synth_pkg::*;

   localparam int NUM_CH = 5;
   localparam int ACC_W  = 32;
   localparam int LOCK   = 3;
   localparam int CH_W   = 3;

   logic              refclk = 1'b0;
   logic              rst_n;
   logic [NUM_CH-1:0] ch_enable;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch;
   logic [ACC_W-1:0]  cfg_inc;
   logic [ACC_W-1:0]  cfg_phase;
   logic              cfg_err;
   logic [NUM_CH-1:0] ce_out;
   logic [NUM_CH-1:0] sq_out;
   logic [NUM_CH-1:0] locked;
   logic              locked_all;

   int checks = 0;
   int errors = 0;

   always #5 refclk = ~refclk;

   clk_enable_synth #(
      .NUM_CH      (NUM_CH),
      .ACC_W       (ACC_W),
      .LOCK_CYCLES (LOCK)
   ) dut (
      .refclk     (refclk),
      .rst_n      (rst_n),
      .ch_enable  (ch_enable),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_inc    (cfg_inc),
      .cfg_phase  (cfg_phase),
      .cfg_err    (cfg_err),
      .ce_out     (ce_out),
      .sq_out     (sq_out),
      .locked     (locked),
      .locked_all (locked_all)
   );

   typedef struct packed {
      logic [NUM_CH-1:0] en;
      logic              vld;
      logic [CH_W-1:0]   ch;
      logic [1:0]        incq;
      logic [1:0]        phq;
      logic              rdy;
      logic              err;
      logic [NUM_CH-1:0] ce;
      logic [NUM_CH-1:0] sq;
      logic [NUM_CH-1:0] lk;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [NUM_CH-1:0] en, input logic vld, input logic [CH_W-1:0] ch,
                      input logic [1:0] incq, input logic [1:0] phq, input logic rdy, input logic err,
                      input logic [NUM_CH-1:0] ce, input logic [NUM_CH-1:0] sq, input logic [NUM_CH-1:0] lk);
      vec_t v;
      v = '{en: en, vld: vld, ch: ch, incq: incq, phq: phq, rdy: rdy, err: err, ce: ce, sq: sq, lk: lk};
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic rdy, input logic err,
                           input logic [NUM_CH-1:0] ce, input logic [NUM_CH-1:0] sq,
                           input logic [NUM_CH-1:0] lk);
      chk({tag, " cfg_ready"}, 32'(cfg_ready), 32'(rdy));
      chk({tag, " cfg_err"}, 32'(cfg_err), 32'(err));
      chk({tag, " ce_out"}, 32'(ce_out), 32'(ce));
      chk({tag, " sq_out"}, 32'(sq_out), 32'(sq));
      chk({tag, " locked"}, 32'(locked), 32'(lk));
      chk({tag, " locked_all"}, 32'(locked_all), 32'(&lk));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] r64;
      logic [NUM_CH-1:0] seq_ce[4];
      logic [NUM_CH-1:0] seq_sq[4];
      logic [NUM_CH-1:0] seq_lk[4];

      rst_n     = 1'b0;
      ch_enable = '0;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_inc   = '0;
      cfg_phase = '0;

      // en, vld, ch, inc, phase | rdy, err, ce, sq, locked
      add(5'b00001, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b00001, 5'b00000);
      add(5'b00001, 0, 0, 0, 0, 1, 0, 5'b00001, 5'b00000, 5'b00000);
      add(5'b00001, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b00001, 5'b00000);
      add(5'b00001, 0, 0, 0, 0, 1, 0, 5'b00001, 5'b00000, 5'b00001);
      add(5'b00011, 1, 1, 1, 0, 0, 0, 5'b00000, 5'b00001, 5'b00001);
      add(5'b00011, 0, 0, 0, 0, 1, 0, 5'b00001, 5'b00000, 5'b00001);
      add(5'b00011, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b00011, 5'b00001);
      add(5'b00011, 0, 0, 0, 0, 1, 0, 5'b00001, 5'b00010, 5'b00001);
      add(5'b00011, 0, 0, 0, 0, 1, 0, 5'b00010, 5'b00001, 5'b00011);
      add(5'b00011, 0, 0, 0, 0, 1, 0, 5'b00001, 5'b00000, 5'b00011);
      add(5'b00011, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b00011, 5'b00011);
      add(5'b00011, 0, 0, 0, 0, 1, 0, 5'b00001, 5'b00010, 5'b00011);
      add(5'b00011, 0, 0, 0, 0, 1, 0, 5'b00010, 5'b00001, 5'b00011);
      add(5'b00111, 0, 0, 0, 0, 1, 0, 5'b00001, 5'b00100, 5'b00011);
      add(5'b00111, 0, 0, 0, 0, 1, 0, 5'b00100, 5'b00011, 5'b00011);
      add(5'b00111, 0, 0, 0, 0, 1, 0, 5'b00001, 5'b00110, 5'b00011);
      add(5'b00111, 0, 0, 0, 0, 1, 0, 5'b00110, 5'b00001, 5'b00111);
      add(5'b00111, 1, 2, 1, 3, 0, 0, 5'b00001, 5'b00100, 5'b00011);
      add(5'b00111, 0, 0, 0, 0, 1, 0, 5'b00100, 5'b00011, 5'b00011);
      add(5'b00111, 1, 5, 0, 0, 0, 1, 5'b00001, 5'b00010, 5'b00011);
      add(5'b00111, 0, 0, 0, 0, 1, 0, 5'b00010, 5'b00101, 5'b00011);
      add(5'b00111, 1, 0, 0, 1, 0, 0, 5'b00000, 5'b00100, 5'b00110);
      add(5'b00111, 1, 1, 1, 2, 1, 0, 5'b00100, 5'b00010, 5'b00110);
      add(5'b00111, 1, 1, 1, 2, 0, 0, 5'b00000, 5'b00010, 5'b00100);
      add(5'b00111, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b00110, 5'b00100);
      add(5'b00011, 0, 0, 0, 0, 1, 0, 5'b00010, 5'b00100, 5'b00000);
      add(5'b00011, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b00100, 5'b00000);
      add(5'b00011, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b00110, 5'b00010);
      add(5'b00001, 1, 1, 2, 3, 0, 0, 5'b00000, 5'b00110, 5'b00000);
      add(5'b00001, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b00110, 5'b00000);
      add(5'b00011, 0, 0, 0, 0, 1, 0, 5'b00010, 5'b00100, 5'b00000);
      add(5'b00011, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b00110, 5'b00000);
      add(5'b00011, 0, 0, 0, 0, 1, 0, 5'b00010, 5'b00100, 5'b00000);

      r64 = inc_for(64'd100_000_000, 64'd25_000_000, 32);
      chk("inc_for 25M/100M", r64[31:0], 32'h4000_0000);
      r64 = inc_for(64'd3, 64'd1, 4);
      chk("inc_for round down", r64[31:0], 32'd5);
      r64 = inc_for(64'd3, 64'd2, 4);
      chk("inc_for round up", r64[31:0], 32'd11);

      repeat (2) @(negedge refclk);
      chk_outs("reset", 1'b1, 1'b0, '0, '0, '0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         ch_enable = vecs[i].en;
         cfg_valid = vecs[i].vld;
         cfg_ch    = vecs[i].ch;
         cfg_inc   = {vecs[i].incq, 30'd0};
         cfg_phase = {vecs[i].phq, 30'd0};
         @(posedge refclk);
         @(negedge refclk);
         chk_outs($sformatf("vec%0d", i + 1), vecs[i].rdy, vecs[i].err,
                  vecs[i].ce, vecs[i].sq, vecs[i].lk);
      end

      // Asynchronous reset in the middle of a cycle with ce_out high
      cfg_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_outs("async reset", 1'b1, 1'b0, '0, '0, '0);
      @(negedge refclk);
      @(negedge refclk);
      rst_n     = 1'b1;
      ch_enable = '1;

      seq_ce = '{5'b00000, 5'b11111, 5'b00000, 5'b11111};
      seq_sq = '{5'b11111, 5'b00000, 5'b11111, 5'b00000};
      seq_lk = '{5'b00000, 5'b00000, 5'b00000, 5'b11111};
      for (int k = 0; k < 4; k++) begin
         @(posedge refclk);
         @(negedge refclk);
         chk_outs($sformatf("restart%0d", k + 1), 1'b1, 1'b0, seq_ce[k], seq_sq[k], seq_lk[k]);
      end

      ch_enable = 5'b10111;
      @(posedge refclk);
      @(negedge refclk);
      chk_outs("drop ch3", 1'b1, 1'b0, 5'b00000, 5'b10111, 5'b10111);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
